// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and flag indices shared by the ALU arbiter
package alu_pkg;
  localparam logic [5:0] OP_PASSA = 6'h00;
  localparam logic [5:0] OP_PASSB = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_NOR   = 6'h05;
  localparam logic [5:0] OP_NOT   = 6'h06;
  localparam logic [5:0] OP_SLL   = 6'h07;
  localparam logic [5:0] OP_SRL   = 6'h08;
  localparam logic [5:0] OP_ROR   = 6'h09;
  localparam logic [5:0] OP_SRA   = 6'h0A;
  localparam logic [5:0] OP_SLT   = 6'h0B;
  localparam logic [5:0] OP_ADD   = 6'h0C;
  localparam logic [5:0] OP_ADDU  = 6'h0D;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
  // Only the adders report meaningful carry/overflow; other ops mask them.
  function automatic logic has_cv(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_ADDU);
  endfunction
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant from valid and priority pointer
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);
  // Both valid: pointer decides; otherwise whichever single port is valid wins.
  always_comb begin
    idx_o = (valid_i == 2'b11) ? ptr_i : valid_i[1];
    gnt_o = (valid_i == 2'b00) ? 2'b00 : (idx_o ? 2'b10 : 2'b01);
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int OP_MAX      = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_op0,
  input  logic [5:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [31:0] alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic        busy
);
  state_e      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        owner_q, owner_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        err_q, err_d;
  logic [1:0]  gnt;
  logic        gnt_idx;
  logic [5:0]  sel_op;
  logic [31:0] sel_a, sel_b;
  logic        cv;

  rr_arb2 u_arb (.valid_i(req_valid), .ptr_i(rr_ptr_q), .gnt_o(gnt), .idx_o(gnt_idx));

  // Operand mux for the port being granted this cycle.
  always_comb begin
    sel_op = gnt_idx ? req_op1 : req_op0;
    sel_a  = gnt_idx ? req_a1 : req_a0;
    sel_b  = gnt_idx ? req_b1 : req_b0;
    cv     = has_cv(op_q);
  end

  // Next-state: grant in IDLE, count and capture in EXEC, hold until consumed in RESP.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        owner_d  = gnt_idx;
        rr_ptr_d = ~gnt_idx;
        cnt_d    = '0;
        if (sel_op <= 6'(OP_MAX)) begin
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = EXEC;
        end else begin
          result_d = '0;
          flags_d  = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      EXEC: if (cnt_q == 4'(EXEC_CYCLES - 1)) begin
        result_d        = alu_res;
        flags_d[FLG_Z]  = (alu_res == 32'd0);
        flags_d[FLG_N]  = alu_res[31];
        flags_d[FLG_C]  = cv & alu_c;
        flags_d[FLG_V]  = cv & alu_v;
        err_d           = 1'b0;
        state_d         = RESP;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      RESP: state_d = rsp_ready[owner_q] ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  // Operand regs double as ALU drivers, so they naturally hold outside EXEC.
  always_comb begin
    req_ready  = (state_q == IDLE && !reset) ? gnt : 2'b00;
    rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_result = result_q;
    rsp_flags  = flags_q;
    rsp_err    = err_q;
    alu_op     = {26'b0, op_q};
    alu_a      = a_q;
    alu_b      = b_q;
    busy       = (state_q != IDLE);
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural ALU beside it
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset3 = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [5:0]  req_op0 = '0, req_op1 = '0;
  logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [1:0]  rsp_ready = 2'b11;
  logic [1:0]  req_ready, rsp_valid, req_ready3, rsp_valid3;
  logic [31:0] rsp_result, alu_op, alu_a, alu_b, alu_res;
  logic [31:0] rsp_result3, alu_op3, alu_a3, alu_b3, alu_res3;
  logic [3:0]  rsp_flags, rsp_flags3;
  logic        rsp_err, alu_c, alu_v, busy, rsp_err3, alu_c3, alu_v3, busy3;
  int checks = 0, failures = 0;

  typedef struct {logic port; logic [31:0] res; logic [3:0] flags; logic err;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Reference ALU: carry/overflow always computed from A+B so masking is observable.
  function automatic logic [33:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      6'h00: r = a;
      6'h01: r = b;
      6'h02: r = a & b;
      6'h03: r = a | b;
      6'h04: r = a ^ b;
      6'h0A: r = 32'($signed(a) >>> b[4:0]);
      6'h0C, 6'h0D: r = s[31:0];
      default: r = 32'd0;
    endcase
    return {s[32], (a[31] == b[31]) && (s[31] != a[31]), r};
  endfunction

  assign {alu_c, alu_v, alu_res}    = alu_fn(alu_op[5:0], alu_a, alu_b);
  assign {alu_c3, alu_v3, alu_res3} = alu_fn(alu_op3[5:0], alu_a3, alu_b3);

  alu_arbiter #(.EXEC_CYCLES(1), .OP_MAX(13)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .alu_c(alu_c), .alu_v(alu_v), .busy(busy));

  alu_arbiter #(.EXEC_CYCLES(3), .OP_MAX(13)) u_dut3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid), .req_ready(req_ready3),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result3), .rsp_flags(rsp_flags3), .rsp_err(rsp_err3),
    .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_res(alu_res3),
    .alu_c(alu_c3), .alu_v(alu_v3), .busy(busy3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else begin req_op1 = op; req_a1 = a; req_b1 = b; end
  endtask

  task automatic issue(input string tag, input int p, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef, input logic ee);
    drive(p, op, a, b);
    req_valid[p] = 1'b1;
    #1;
    chk({tag, "_ready"}, 160'(req_ready), 160'(p == 0 ? 2'b01 : 2'b10));
    sb.push_back('{port: p[0], res: er, flags: ef, err: ee});
    tick();
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int p, output int n);
    n = 1;
    while (!rsp_valid[p] && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 160'(sb.size()), 160'(1));
    end else begin
      e = sb.pop_front();
      chk(tag, {rsp_valid, rsp_result, rsp_flags, rsp_err},
          {e.port ? 2'b10 : 2'b01, e.res, e.flags, e.err});
    end
  endtask

  initial begin
    int n;
    logic seen;
    repeat (3) tick();
    chk("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err, alu_op, alu_a, alu_b, busy}, '0);
    reset = 1'b0;

    issue("addu_wrap", 0, 6'h0D, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b1010, 1'b0);
    wait_rsp(0, n);
    chk("addu_latency", 160'(n), 160'(2));
    check_rsp("addu_rsp");
    tick();
    chk("addu_done", 160'(rsp_valid), 160'(2'b00));

    reset = 1'b1;
    drive(0, 6'h02, 32'h0000F0F0, 32'h00000FF0);
    drive(1, 6'h03, 32'd1, 32'd2);
    req_valid = 2'b11;
    #1;
    chk("ready_in_reset", 160'(req_ready), 160'(2'b00));
    tick();
    reset = 1'b0;
    #1;
    chk("both_grant_p0", 160'(req_ready), 160'(2'b01));
    sb.push_back('{port: 1'b0, res: 32'h000000F0, flags: 4'b0000, err: 1'b0});
    sb.push_back('{port: 1'b1, res: 32'h00000003, flags: 4'b0000, err: 1'b0});
    tick();
    req_valid = 2'b10;
    #1;
    chk("p1_waits_exec", 160'(req_ready), 160'(2'b00));
    wait_rsp(0, n);
    chk("and_latency", 160'(n), 160'(2));
    check_rsp("and_rsp");
    chk("p1_waits_resp", 160'(req_ready), 160'(2'b00));
    tick();
    chk("p1_grant_after_resp", {rsp_valid, req_ready}, {2'b00, 2'b10});
    tick();
    req_valid = 2'b00;
    wait_rsp(1, n);
    chk("or_latency", 160'(n), 160'(2));
    check_rsp("or_rsp");
    tick();
    req_valid = 2'b11;
    #1;
    chk("rr_ptr_back_to_0", 160'(req_ready), 160'(2'b01));
    req_valid = 2'b00;
    #1;

    issue("illegal", 1, 6'h20, 32'hDEADBEEF, 32'hCAFEF00D, 32'd0, 4'b0000, 1'b1);
    wait_rsp(1, n);
    chk("illegal_latency", 160'(n), 160'(1));
    check_rsp("illegal_rsp");
    chk("illegal_alu_held", {alu_op, alu_a, alu_b}, {32'd3, 32'd1, 32'd2});
    tick();

    rsp_ready = 2'b10;
    issue("bp", 0, 6'h02, 32'hFFFF0000, 32'h12345678, 32'h12340000, 4'b0000, 1'b0);
    wait_rsp(0, n);
    chk("bp_latency", 160'(n), 160'(2));
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, rsp_result, rsp_flags, rsp_err, req_ready},
          {2'b01, 32'h12340000, 4'b0000, 1'b0, 2'b00});
      tick();
    end
    check_rsp("bp_rsp");
    drive(0, 6'h0A, 32'h80000000, 32'd4);
    rsp_ready = 2'b11;
    #1;
    chk("same_cycle_no_grant", 160'(req_ready), 160'(2'b00));
    tick();
    issue("sra", 0, 6'h0A, 32'h80000000, 32'd4, 32'hF8000000, 4'b0100, 1'b0);
    wait_rsp(0, n);
    chk("sra_latency", 160'(n), 160'(2));
    check_rsp("sra_rsp");
    tick();

    issue("add_ovf", 1, 6'h0C, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b0101, 1'b0);
    wait_rsp(1, n);
    check_rsp("add_ovf_rsp");
    tick();

    reset = 1'b1;
    tick();
    reset3 = 1'b0;
    drive(0, 6'h0C, 32'd5, 32'd6);
    req_valid = 2'b01;
    #1;
    chk("e3_grant", 160'(req_ready3), 160'(2'b01));
    tick();
    req_valid = 2'b00;
    chk("e3_exec", {busy3, alu_op3}, {1'b1, 32'h0C});
    tick();
    reset3 = 1'b1;
    tick();
    chk("e3_reset_outputs", {req_ready3, rsp_valid3, rsp_result3, rsp_flags3, rsp_err3, alu_op3, alu_a3, alu_b3, busy3}, '0);
    reset3 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= |rsp_valid3;
    end
    chk("e3_no_response", 160'(seen), 160'(0));
    drive(1, 6'h03, 32'd1, 32'd2);
    req_valid = 2'b10;
    #1;
    chk("e3_regrant", 160'(req_ready3), 160'(2'b10));
    tick();
    req_valid = 2'b00;
    n = 1;
    while (!rsp_valid3[1] && n < 20) begin
      tick();
      n++;
    end
    chk("e3_latency", 160'(n), 160'(4));
    chk("e3_rsp", {rsp_valid3, rsp_result3, rsp_flags3, rsp_err3}, {2'b10, 32'd3, 4'b0000, 1'b0});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
